sr_digit_scan_ctrl: RTL and testbench

- Refresh scheduler for the serial seven-segment display path.
- Holds one 8-bit abcdefgh pattern per digit, written by the user logic.
- Scans the digits round-robin and hands each {one-hot digit, abcdefgh} pair to the shift-register driver over a valid/ready handshake.
- Holds each digit for a programmable dwell time. Sits between top-level user logic and the sr driver, in the driver's clock domain (the slow clock).

---
 rtl/sr_digit_scan_ctrl_if.sv | 13 +
 rtl/sr_digit_scan_ctrl.sv | 99 +++++++++
 tb/tb_sr_digit_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_digit_scan_ctrl_if.sv
// Handshake bundle between the digit scan controller and the shift-register driver.
// The controller is the master: it presents {digit, abcdefgh} with drv_load, the driver answers with drv_ready.
interface sr_digit_scan_ctrl_if #(
  parameter int w_digit = 4
);
  logic                drv_load;
  logic                drv_ready;
  logic [w_digit-1:0]  digit;
  logic [7:0]          abcdefgh;

  modport master (output drv_load, digit, abcdefgh, input drv_ready);
  modport slave  (input drv_load, digit, abcdefgh, output drv_ready);
endinterface

// File: rtl/sr_digit_scan_ctrl.sv
// Round-robin refresh scheduler: hands one {one-hot digit, pattern} pair per digit to the sr driver.
// Latency: pair valid one cycle after fetch; per-digit period dwell_cycles+2 with drv_ready high.
// Backpressure: drv_load and the pair are held stable until drv_ready; pattern writes never stall.
module sr_digit_scan_ctrl #(
  parameter int w_digit      = 4,
  parameter int dwell_cycles = 1000,
  parameter int w_idx        = $clog2(w_digit)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [w_idx-1:0]     wr_addr,
  input  logic [7:0]           wr_data,
  input  logic                 blank,
  output logic [w_idx-1:0]     scan_idx,
  output logic                 frame_done,
  sr_digit_scan_ctrl_if.master drv
);

  localparam int w_cnt = (dwell_cycles > 1) ? $clog2(dwell_cycles) : 1;
  localparam logic [w_cnt-1:0]   dwell_load = w_cnt'(dwell_cycles - 1);
  localparam logic [w_idx-1:0]   last_idx   = w_idx'(w_digit - 1);
  localparam logic [w_idx:0]     n_digit    = (w_idx + 1)'(w_digit);
  localparam logic [w_digit-1:0] one_digit  = w_digit'(1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    REQ   = 2'd1,
    DWELL = 2'd2
  } state_t;

  state_t            state;
  logic [w_cnt-1:0]  dwell_cnt;
  logic [7:0]        pattern [w_digit];
  logic              wr_ok;

  // The index is one bit wider than wr_addr so non-power-of-two digit counts can reject stray writes.
  assign wr_ok = wr_en && ({1'b0, wr_addr} < n_digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < w_digit; i++) begin
        pattern[i] <= '0;
      end
    end else if (wr_ok) begin
      pattern[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      dwell_cnt    <= '0;
      scan_idx     <= '0;
      frame_done   <= 1'b0;
      drv.drv_load <= 1'b0;
      drv.digit    <= '0;
      drv.abcdefgh <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        FETCH: begin
          // Reads the pre-edge pattern, so a same-cycle write shows up on the next visit.
          if (blank) begin
            drv.digit    <= '0;
            drv.abcdefgh <= '0;
          end else begin
            drv.digit    <= one_digit << scan_idx;
            drv.abcdefgh <= pattern[scan_idx];
          end
          drv.drv_load <= 1'b1;
          state        <= REQ;
        end
        REQ: begin
          if (drv.drv_ready) begin
            drv.drv_load <= 1'b0;
            dwell_cnt    <= dwell_load;
            state        <= DWELL;
          end
        end
        DWELL: begin
          if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end else begin
            if (scan_idx == last_idx) begin
              scan_idx   <= '0;
              frame_done <= 1'b1;
            end else begin
              scan_idx <= scan_idx + 1'b1;
            end
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_digit_scan_ctrl.sv
// Scoreboard bench: a transfer-level model predicts each pair and frame_done pulse, a negedge monitor checks them.
// Two instances: 4 digits / dwell 3, and 3 digits / dwell 1 (which also sees out-of-range write addresses).
module tb_sr_digit_scan_ctrl;

  localparam int W0 = 4, D0 = 3;
  localparam int W1 = 3, D1 = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       blank;
  logic       ready;
  logic [1:0] sidx_a, sidx_b;
  logic       fd_a, fd_b;

  sr_digit_scan_ctrl_if #(.w_digit(W0)) ifa ();
  sr_digit_scan_ctrl_if #(.w_digit(W1)) ifb ();

  sr_digit_scan_ctrl #(.w_digit(W0), .dwell_cycles(D0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .blank(blank), .scan_idx(sidx_a), .frame_done(fd_a), .drv(ifa)
  );

  sr_digit_scan_ctrl #(.w_digit(W1), .dwell_cycles(D1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .blank(blank), .scan_idx(sidx_b), .frame_done(fd_b), .drv(ifb)
  );

  assign ifa.drv_ready = ready;
  assign ifb.drv_ready = ready;

  always #5 clk = ~clk;

  logic       ld  [2];
  logic [3:0] dig [2];
  logic [7:0] seg [2];
  logic [1:0] sidx[2];
  logic       fdo [2];
  assign ld[0] = ifa.drv_load;  assign ld[1] = ifb.drv_load;
  assign dig[0] = ifa.digit;    assign dig[1] = {1'b0, ifb.digit};
  assign seg[0] = ifa.abcdefgh; assign seg[1] = ifb.abcdefgh;
  assign sidx[0] = sidx_a;      assign sidx[1] = sidx_b;
  assign fdo[0] = fd_a;         assign fdo[1] = fd_b;

  typedef struct {
    logic [3:0] dig;
    logic [7:0] seg;
    logic [1:0] idx;
    int         fcyc;
  } item_t;

  item_t expq [2][$];
  int    fdq  [2][$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    ntx [2];

  // Reference model: works per transfer, not per FSM state.
  int         wd [2] = '{W0, W1};
  int         dw [2] = '{D0, D1};
  int         nf [2];
  bit         waiting [2];
  int         idx [2];
  logic [7:0] pat [2][4];

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int j = 0; j < 4; j++) pat[k][j] = 8'h00;
        idx[k] = 0;
        waiting[k] = 0;
        nf[k] = cyc + 1;
        expq[k].delete();
        fdq[k].delete();
      end else begin
        if (waiting[k]) begin
          if (ready) begin
            waiting[k] = 0;
            nf[k] = cyc + dw[k] + 1;
            if (idx[k] == wd[k] - 1) fdq[k].push_back(cyc + dw[k]);
            idx[k] = (idx[k] + 1) % wd[k];
          end
        end else if (cyc == nf[k]) begin
          item_t it;
          it.dig  = blank ? 4'd0 : 4'(1 << idx[k]);
          it.seg  = blank ? 8'd0 : pat[k][idx[k]];
          it.idx  = 2'(idx[k]);
          it.fcyc = cyc;
          expq[k].push_back(it);
          waiting[k] = 1;
        end
        if (wr_en && int'(wr_addr) < wd[k]) pat[k][wr_addr] = wr_data;
      end
    end
  end

  // Monitor on the falling edge.
  logic prev_ld [2];
  int   rise_cyc [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        prev_ld[k] = 1'b0;
      end else begin
        if (ld[k] && !prev_ld[k]) rise_cyc[k] = cyc;
        prev_ld[k] = ld[k];
        if (ld[k]) begin
          if (expq[k].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_load inst%0d cyc %0d: drv_load=1 with no predicted pair", k, cyc);
          end else if (ready) begin
            item_t it;
            it = expq[k].pop_front();
            ntx[k]++;
            checks++;
            if (dig[k] !== it.dig || seg[k] !== it.seg || sidx[k] !== it.idx) begin
              errors++;
              $display("FAIL pair inst%0d cyc %0d: got digit=%b seg=%h idx=%0d, want digit=%b seg=%h idx=%0d",
                       k, cyc, dig[k], seg[k], sidx[k], it.dig, it.seg, it.idx);
            end
            checks++;
            if (rise_cyc[k] != it.fcyc) begin
              errors++;
              $display("FAIL load_timing inst%0d: drv_load rose at cyc %0d, want %0d", k, rise_cyc[k], it.fcyc);
            end
          end else begin
            checks++;
            if (dig[k] !== expq[k][0].dig || seg[k] !== expq[k][0].seg) begin
              errors++;
              $display("FAIL stall_hold inst%0d cyc %0d: got digit=%b seg=%h, want digit=%b seg=%h",
                       k, cyc, dig[k], seg[k], expq[k][0].dig, expq[k][0].seg);
            end
          end
        end
        if (fdo[k] || (fdq[k].size() > 0 && fdq[k][0] == cyc)) begin
          bit exp_fd;
          exp_fd = (fdq[k].size() > 0 && fdq[k][0] == cyc);
          checks++;
          if (fdo[k] !== exp_fd) begin
            errors++;
            $display("FAIL frame_done inst%0d cyc %0d: got %b want %b", k, cyc, fdo[k], exp_fd);
          end
          if (exp_fd) void'(fdq[k].pop_front());
        end
      end
    end
  end

  function automatic bit cond(int which);
    case (which)
      0: return ld[0] && sidx[0] == 2'd2;
      1: return ld[0] && sidx[0] == 2'd0;
      2: return sidx[0] == 2'd1;
      3: return fdo[0];
      4: return ld[0] && sidx[0] == 2'd3;
      5: return !ld[0];
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic wait_cond(int which, string name);
    int i;
    i = 0;
    while (!cond(which) && i < 200) begin
      step(1);
      i++;
    end
    checks++;
    if (!cond(which)) begin
      errors++;
      $display("FAIL wait_%s: condition not reached within %0d cycles, want reached", name, i);
    end
  endtask

  task automatic check_zero(string name);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ld[k] !== 1'b0 || dig[k] !== 4'd0 || seg[k] !== 8'd0 || sidx[k] !== 2'd0 || fdo[k] !== 1'b0) begin
        errors++;
        $display("FAIL %s inst%0d: got load=%b digit=%b seg=%h idx=%0d fd=%b, want all zero",
                 name, k, ld[k], dig[k], seg[k], sidx[k], fdo[k]);
      end
    end
  endtask

  task automatic write(logic [1:0] a, logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step(1);
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; blank = 1'b0; ready = 1'b0;
    ntx[0] = 0; ntx[1] = 0;
    step(3);
    check_zero("reset_state");
    rst_n = 1'b1;
    ready = 1'b1;
    // Basic scan; the first write collides with the first fetch of index 0.
    write(2'd0, 8'h11); write(2'd1, 8'h22); write(2'd2, 8'h44); write(2'd3, 8'h88);
    step(40);
    // Backpressure during REQ of index 2.
    wait_cond(0, "req_idx2");
    ready = 1'b0;
    step(10);
    ready = 1'b1;
    step(20);
    // Blank during FETCH of index 1, released in DWELL.
    wait_cond(1, "req_idx0");
    wait_cond(2, "fetch_idx1");
    blank = 1'b1;
    step(2);
    blank = 1'b0;
    step(20);
    // Write collision on index 0 fetch, then an address out of range for the 3-digit instance.
    wait_cond(3, "fetch_idx0");
    write(2'd0, 8'hFF);
    write(2'd3, 8'h5A);
    step(40);
    // Reset in DWELL of index 3.
    wait_cond(4, "req_idx3");
    wait_cond(5, "dwell_idx3");
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    step(2);
    rst_n = 1'b1;
    step(20);
    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      ready   = ($urandom_range(0, 3) != 0);
      blank   = ($urandom_range(0, 9) == 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 8'($urandom);
      step(1);
    end
    wr_en = 1'b0; blank = 1'b0; ready = 1'b1;
    step(10);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ntx[k] < 100 || expq[k].size() > 1) begin
        errors++;
        $display("FAIL progress inst%0d: transfers=%0d pending=%0d, want >=100 and <=1", k, ntx[k], expq[k].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
